sound_sequencer: RTL and testbench
==================================

Name: sound_sequencer

Overview:
- Autonomous note sequencer placed between the CPU I/O bus and the 4-channel square-wave sound block.
- CPU queues timed note commands into a FIFO. The sequencer pops each command, writes the divider word to the sound block's single-word write port, and holds for the programmed duration. It can optionally silence the channel afterwards.
- CPU is freed from cycle-accurate note timing; a stop control flushes the queue and mutes all channels.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz); at least 1.
- DUR_W, 12, duration field width in ticks.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_wr_en  in  1  CPU write strobe, one-cycle
- cpu_addr  in  1  0 = note latch, 1 = duration/push
- cpu_data  in  16  CPU write data
- stop  in  1  flush queue and mute all channels
- pause  in  1  level; freezes duration timing
- snd_wr_en  out  1  write strobe to sound block
- snd_data  out  16  [15:14] channel, [13:0] divider
- fifo_count  out  $clog2(DEPTH)+1  entries queued
- busy  out  1  state != IDLE or FIFO non-empty
- overflow  out  1  sticky; a push was dropped

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset:
  - snd_wr_en=0, snd_data=0, fifo_count=0, busy=0, overflow=0.
  - State IDLE, note latch=0, FIFO emptied.
  - rst mid-operation aborts with no release or silence writes.
- CPU writes:
  - addr 0 stores cpu_data in the note latch. Nothing is pushed.
  - addr 1 pushes the 29-bit entry {note_latch[15:0], rel=cpu_data[15], dur=cpu_data[DUR_W-1:0]}.
  - The note latch is retained, so repeated addr-1 writes replay the same note.
- Full FIFO:
  - A push while fifo_count==DEPTH is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A pop and push in the same cycle while not full leave the count unchanged.
- FSM states: IDLE, FETCH, ISSUE, WAIT, RELEASE, SILENCE.
  - IDLE: if FIFO non-empty, pop, then go to FETCH.
  - FETCH: register the popped entry, then go to ISSUE.
  - ISSUE: snd_wr_en=1 and snd_data=note for exactly 1 cycle.
    - dur!=0: go to WAIT.
    - dur==0 and rel=1: go to RELEASE.
    - dur==0 and rel=0: go to IDLE. This lets chords go out at 3 cycles per note.
  - WAIT:
    - Prescaler restarts at 0 on entry and produces a tick every TICK_DIV cycles.
    - Each tick decrements the remaining duration.
    - When it reaches 0: go to RELEASE if rel=1, else IDLE.
    - WAIT lasts exactly dur*TICK_DIV cycles while pause=0.
    - pause=1 holds both the prescaler and the remaining count. pause has no effect in other states.
  - RELEASE: 1 cycle with snd_wr_en=1 and snd_data={note[15:14],14'd0}, then go to IDLE.
  - SILENCE: 4 consecutive cycles of snd_wr_en=1 with snd_data 0x0000, 0x4000, 0x8000, 0xC000, then go to IDLE.
- stop:
  - Highest priority below rst, from any state: clear the FIFO and overflow, go to SILENCE the next cycle.
  - An in-progress ISSUE/RELEASE write is not repeated.
  - stop asserted during SILENCE restarts the 4-write sequence.
  - CPU pushes in the stop cycle or during SILENCE are ignored; overflow is not set.
- Latency: push sampled at edge E0 with the sequencer IDLE and the FIFO empty means snd_wr_en is high in the cycle after edge E2.
- snd_wr_en is never high on two consecutive cycles except in SILENCE.
- Widths: the duration counter is DUR_W bits and the prescaler is $clog2(TICK_DIV) bits, with wrap at TICK_DIV-1. No arithmetic overflow is possible.

Decomposition:
- Shared header sound_defs.vh holds:
  - channel codes CH0..CH3 (2'b00..2'b11);
  - entry field positions (NOTE 28:13, REL 12, DUR 11:0);
  - FSM state encodings;
  - CPU address codes.
- One sub-module, seq_fifo: synchronous FIFO with registered read data.
  - Parameters WIDTH, DEPTH.
  - Ports: push, pop, clear, din, dout, count, full, empty.

Test Plan (TICK_DIV=4, DEPTH=4):
- Reset, then write addr0=0x4123 and addr1=0x8003 -> snd_wr_en with 0x4123 two edges after the push; 12 cycles later snd_wr_en with 0x4000; busy falls the next cycle.
- Push three dur=0, rel=0 notes 0x0010, 0x4020, 0x8030 back-to-back -> three writes spaced exactly 3 cycles apart, with values in that order.
- Push 5 entries while the first is in WAIT with dur=100 -> 4 accepted after the first pop frees a slot. overflow=1 only if count==4 at a push; check fifo_count each cycle.
- Assert pause for 7 cycles during WAIT with dur=2 -> release write occurs at 8+7 cycles after ISSUE.
- Queue 3 entries and assert stop mid-WAIT -> FIFO count 0, overflow 0, then writes 0x0000, 0x4000, 0x8000, 0xC000 on 4 consecutive cycles, then IDLE with no further writes.
- Assert rst during RELEASE and during SILENCE -> all outputs at reset values the next cycle, with no further snd_wr_en.

Source files
------------

// File: rtl/sound_sequencer_pkg.sv
// Shared definitions for the sound sequencer: channel codes, CPU address
// codes, FSM state encoding and the helper that builds a "channel at divider
// zero" word for the sound block.
package sound_sequencer_pkg;

  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH3 = 2'b11;

  localparam logic ADDR_NOTE = 1'b0;  // write note latch
  localparam logic ADDR_PUSH = 1'b1;  // write duration, push entry

  localparam int NOTE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE,
    ST_SILENCE
  } state_t;

  // Divider 0 on a given channel mutes that channel.
  function automatic logic [15:0] chan_zero_word(input logic [1:0] ch);
    return {ch, 14'd0};
  endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Bus bundle between the CPU-side master and the sequencer.
//   cpu_wr_en/cpu_addr/cpu_data : CPU write port (addr 0 note, addr 1 push)
//   stop/pause                  : flush+mute request, duration freeze level
//   snd_wr_en/snd_data          : single-word write port to the sound block
//   fifo_count/busy/overflow    : status back to the CPU
interface sound_sequencer_if #(
  parameter int DEPTH = 16
);
  logic                     cpu_wr_en;
  logic                     cpu_addr;
  logic [15:0]              cpu_data;
  logic                     stop;
  logic                     pause;
  logic                     snd_wr_en;
  logic [15:0]              snd_data;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     busy;
  logic                     overflow;

  modport master (
    output cpu_wr_en, cpu_addr, cpu_data, stop, pause,
    input  snd_wr_en, snd_data, fifo_count, busy, overflow
  );

  modport slave (
    input  cpu_wr_en, cpu_addr, cpu_data, stop, pause,
    output snd_wr_en, snd_data, fifo_count, busy, overflow
  );
endinterface

// File: rtl/sound_sequencer_fifo.sv
// seq_fifo: synchronous FIFO with registered read data.
//   push/pop   : requests; push when full and pop when empty are ignored
//   clear      : empties the FIFO (wins over push/pop)
//   din/dout   : dout updates on the edge that accepts a pop
//   count/full/empty : occupancy status
module seq_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage and read register carry data only, so they are not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
    if (do_pop)  dout_q <= mem_q[rd_ptr_q];
  end

  assign dout  = dout_q;
  assign count = count_q;
endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: pops timed note commands from a FIFO and drives the
// sound block's write port, holding each note for dur*TICK_DIV cycles and
// optionally muting its channel afterwards. stop flushes and mutes all.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sound_sequencer_if.slave (CPU port, stop/pause, sound port,
//              fifo_count/busy/overflow status)
module sound_sequencer
  import sound_sequencer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  sound_sequencer_if.slave  bus
);
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW       = NOTE_W + 1 + DUR_W;
  localparam int REL_BIT  = DUR_W;
  localparam int NOTE_LSB = DUR_W + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t             state_q;
  logic [NOTE_W-1:0]  note_latch_q;
  logic [1:0]         ch_q;
  logic               rel_q;
  logic [DUR_W-1:0]   rem_q;
  logic [PW-1:0]      presc_q;
  logic [1:0]         sil_q;
  logic               wr_q;
  logic [15:0]        data_q;
  logic               ovf_q;

  logic [EW-1:0]      fifo_din, fifo_dout;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty, fifo_pop, push_req;

  // Pushes are ignored in the stop cycle and while the mute sequence runs.
  assign push_req = bus.cpu_wr_en && (bus.cpu_addr == ADDR_PUSH) &&
                    !bus.stop && (state_q != ST_SILENCE);
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty && !bus.stop;
  assign fifo_din = {note_latch_q, bus.cpu_data[15], bus.cpu_data[DUR_W-1:0]};

  seq_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .clear (bus.stop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sound-port outputs are registered: each state sets wr_q/data_q for the
  // cycle the next state occupies, so a write is visible in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      note_latch_q <= '0;
      ch_q         <= CH0;
      rel_q        <= 1'b0;
      rem_q        <= '0;
      presc_q      <= '0;
      sil_q        <= CH0;
      wr_q         <= 1'b0;
      data_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (bus.cpu_wr_en && (bus.cpu_addr == ADDR_NOTE))
        note_latch_q <= bus.cpu_data;

      if (bus.stop) begin
        ovf_q   <= 1'b0;
        state_q <= ST_SILENCE;
        sil_q   <= CH0;
        wr_q    <= 1'b1;
        data_q  <= chan_zero_word(CH0);
      end else begin
        // A full FIFO drops the push even if a pop frees a slot this edge.
        if (push_req && fifo_full) ovf_q <= 1'b1;
        case (state_q)
          ST_IDLE: begin
            if (!fifo_empty) state_q <= ST_FETCH;
          end
          ST_FETCH: begin
            ch_q    <= fifo_dout[EW-1 -: 2];
            rel_q   <= fifo_dout[REL_BIT];
            rem_q   <= fifo_dout[DUR_W-1:0];
            wr_q    <= 1'b1;
            data_q  <= fifo_dout[EW-1:NOTE_LSB];
            state_q <= ST_ISSUE;
          end
          ST_ISSUE: begin
            presc_q <= '0;
            if (rem_q != '0) begin
              state_q <= ST_WAIT;
            end else if (rel_q) begin
              wr_q    <= 1'b1;
              data_q  <= chan_zero_word(ch_q);
              state_q <= ST_RELEASE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_WAIT: begin
            if (!bus.pause) begin
              if (presc_q == PRESC_MAX) begin
                presc_q <= '0;
                rem_q   <= rem_q - DUR_W'(1);
                if (rem_q == DUR_W'(1)) begin
                  if (rel_q) begin
                    wr_q    <= 1'b1;
                    data_q  <= chan_zero_word(ch_q);
                    state_q <= ST_RELEASE;
                  end else begin
                    state_q <= ST_IDLE;
                  end
                end
              end else begin
                presc_q <= presc_q + PW'(1);
              end
            end
          end
          ST_RELEASE: begin
            state_q <= ST_IDLE;
          end
          ST_SILENCE: begin
            if (sil_q == CH3) begin
              state_q <= ST_IDLE;
            end else begin
              sil_q  <= sil_q + 2'd1;
              wr_q   <= 1'b1;
              data_q <= chan_zero_word(sil_q + 2'd1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.snd_wr_en  = wr_q;
  assign bus.snd_data   = data_q;
  assign bus.fifo_count = fifo_count;
  assign bus.busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_sound_sequencer.sv
module tb_sound_sequencer;
  localparam int DEPTH = 4;
  localparam int TD    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sound_sequencer_if #(.DEPTH(DEPTH)) bus ();

  sound_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD), .DUR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queue + timeline of writes ----------
  int          t_m = 0;
  logic [28:0] q_m[$];
  int          sched[int];
  int          rel_at = -1;
  logic [15:0] rel_data;
  int          ws = -1, we = -1;
  int          sil_start = -100;
  int          idle_from = 0;
  logic        ovf_m = 1'b0;
  logic [15:0] latch_m = '0, data_m = '0;
  logic        exp_wr = 1'b0;

  always @(posedge clk) begin
    int c;
    bit full, in_sil, do_pop;
    logic [28:0] e;
    int dur;
    t_m++;
    c = t_m - 1;
    if (rst) begin
      q_m.delete(); sched.delete();
      rel_at = -1; ws = -1; we = -1; sil_start = -100;
      idle_from = t_m; ovf_m = 1'b0; latch_m = '0; data_m = '0;
    end else if (bus.stop) begin
      q_m.delete(); sched.delete();
      rel_at = -1; ws = -1; we = -1; ovf_m = 1'b0;
      sil_start = t_m;
      for (int k = 0; k < 4; k++) sched[t_m + k] = k << 14;
      idle_from = t_m + 4;
      if (bus.cpu_wr_en && bus.cpu_addr == 1'b0) latch_m = bus.cpu_data;
    end else begin
      in_sil = (c >= sil_start) && (c < sil_start + 4);
      // A paused WAIT cycle stretches everything still ahead by one cycle.
      if (bus.pause && c >= ws && c < we) begin
        we++; idle_from++;
        if (rel_at > c) rel_at++;
      end
      full   = (q_m.size() == DEPTH);
      do_pop = (c >= idle_from) && (q_m.size() > 0);
      if (do_pop) begin
        e   = q_m.pop_front();
        dur = int'(e[11:0]);
        sched[t_m + 1] = int'(e[28:13]);
        rel_data = {e[28:27], 14'd0};
        rel_at = -1;
        if (dur != 0) begin
          ws = t_m + 2; we = t_m + 2 + dur * TD;
          if (e[12]) begin rel_at = we; idle_from = we + 1; end
          else idle_from = we;
        end else begin
          ws = -1; we = -1;
          if (e[12]) begin rel_at = t_m + 2; idle_from = t_m + 3; end
          else idle_from = t_m + 2;
        end
      end
      if (bus.cpu_wr_en && bus.cpu_addr == 1'b1 && !in_sil) begin
        if (full) ovf_m = 1'b1;
        else q_m.push_back({latch_m, bus.cpu_data[15], bus.cpu_data[11:0]});
      end
      if (bus.cpu_wr_en && bus.cpu_addr == 1'b0) latch_m = bus.cpu_data;
    end
    exp_wr = sched.exists(t_m) || (rel_at == t_m);
    if (sched.exists(t_m)) data_m = sched[t_m][15:0];
    else if (rel_at == t_m) data_m = rel_data;
  end

  // ---------------- per-cycle compare + write log ---------------------------
  int          log_cyc[$];
  logic [15:0] log_dat[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_wr_en",    32'(bus.snd_wr_en),  32'(exp_wr));
      check("cyc_data",     32'(bus.snd_data),   32'(data_m));
      check("cyc_count",    32'(bus.fifo_count), 32'(q_m.size()));
      check("cyc_busy",     32'(bus.busy),       32'((t_m < idle_from) || (q_m.size() > 0)));
      check("cyc_overflow", 32'(bus.overflow),   32'(ovf_m));
      if (bus.snd_wr_en) begin
        log_cyc.push_back(t_m);
        log_dat.push_back(bus.snd_data);
      end
    end
  end

  function automatic int lc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -1;
  endfunction
  function automatic logic [31:0] ld(input int i);
    return (i < log_dat.size()) ? 32'(log_dat[i]) : 32'hFFFF_FFFF;
  endfunction

  // ---------------- stimulus helpers (called at #1 after a rising edge) ------
  int last_edge;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cpu_wr(input logic a, input logic [15:0] d);
    bus.cpu_wr_en = 1'b1; bus.cpu_addr = a; bus.cpu_data = d;
    @(posedge clk); #1;
    last_edge = t_m;
    bus.cpu_wr_en = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(posedge clk); #1;
    last_edge = t_m;
    bus.stop = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int at);
    int n = 0;
    while (bus.busy && n < max) begin @(posedge clk); #1; n++; end
    at = t_m;
    if (bus.busy) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", max);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"},    32'(bus.snd_wr_en),  32'd0);
    check({tag, "_data"},  32'(bus.snd_data),   32'd0);
    check({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_ovf"},   32'(bus.overflow),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base, e0, s, idle_at;
    bus.cpu_wr_en = 1'b0; bus.cpu_addr = 1'b0; bus.cpu_data = '0;
    bus.stop = 1'b0; bus.pause = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1;
    check_reset_outputs("reset");

    // Single note, dur=3 ticks, release: issue 2 edges after push, 12 WAIT
    // cycles in between, release write, busy drops the next cycle.
    base = log_cyc.size();
    cpu_wr(1'b0, 16'h4123);
    cpu_wr(1'b1, 16'h8003); e0 = last_edge;
    wait_idle(100, idle_at);
    check("t1_nwrites",  32'(log_cyc.size() - base), 32'd2);
    check("t1_note",     ld(base),     32'h4123);
    check("t1_latency",  32'(lc(base) - e0), 32'd2);
    check("t1_release",  ld(base + 1), 32'h4000);
    check("t1_gap",      32'(lc(base + 1) - lc(base)), 32'd13);
    check("t1_busy_off", 32'(idle_at - lc(base + 1)), 32'd1);

    // Chord: three dur=0 rel=0 notes, writes 3 cycles apart in order.
    base = log_cyc.size();
    cpu_wr(1'b0, 16'h0010); cpu_wr(1'b1, 16'h0000);
    cpu_wr(1'b0, 16'h4020); cpu_wr(1'b1, 16'h0000);
    cpu_wr(1'b0, 16'h8030); cpu_wr(1'b1, 16'h0000);
    wait_idle(100, idle_at);
    check("t2_nwrites", 32'(log_cyc.size() - base), 32'd3);
    check("t2_n0", ld(base),     32'h0010);
    check("t2_n1", ld(base + 1), 32'h4020);
    check("t2_n2", ld(base + 2), 32'h8030);
    check("t2_gap01", 32'(lc(base + 1) - lc(base)), 32'd3);
    check("t2_gap12", 32'(lc(base + 2) - lc(base + 1)), 32'd3);

    // Overflow: first entry (dur=100) is popped, then 5 pushes: 4 fit.
    base = log_cyc.size();
    cpu_wr(1'b0, 16'h8ABC);
    cpu_wr(1'b1, 16'h0064);
    for (int i = 0; i < 5; i++) begin
      check("t3_ovf_before", 32'(bus.overflow), 32'd0);
      cpu_wr(1'b1, 16'h8001);
    end
    check("t3_count", 32'(bus.fifo_count), 32'd4);
    check("t3_ovf",   32'(bus.overflow),   32'd1);
    wait_idle(1000, idle_at);
    check("t3_nwrites", 32'(log_cyc.size() - base), 32'd9);
    check("t3_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Pause for 7 cycles inside a dur=2 WAIT: release 1+8+7 after ISSUE.
    base = log_cyc.size();
    cpu_wr(1'b0, 16'hC155);
    cpu_wr(1'b1, 16'h8002);
    tick(3);
    bus.pause = 1'b1;
    tick(7);
    bus.pause = 1'b0;
    wait_idle(100, idle_at);
    check("t4_nwrites", 32'(log_cyc.size() - base), 32'd2);
    check("t4_note",    ld(base),     32'hC155);
    check("t4_release", ld(base + 1), 32'hC000);
    check("t4_gap",     32'(lc(base + 1) - lc(base)), 32'd16);

    // stop mid-WAIT with 3 queued: flush, clear overflow, mute sequence.
    cpu_wr(1'b0, 16'h4077);
    cpu_wr(1'b1, 16'h8032);
    cpu_wr(1'b1, 16'h0001);
    cpu_wr(1'b1, 16'h0001);
    cpu_wr(1'b1, 16'h0001);
    check("t5_count_pre", 32'(bus.fifo_count), 32'd3);
    check("t5_ovf_pre",   32'(bus.overflow),   32'd1);
    tick(5);
    base = log_cyc.size();
    pulse_stop(); s = last_edge;
    check("t5_count_post", 32'(bus.fifo_count), 32'd0);
    check("t5_ovf_post",   32'(bus.overflow),   32'd0);
    cpu_wr(1'b1, 16'h0005);
    tick(4);
    check("t5_push_ignored", 32'(bus.fifo_count), 32'd0);
    tick(20);
    check("t5_nwrites", 32'(log_cyc.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("t5_sil_data", ld(base + k), 32'(k << 14));
      check("t5_sil_cyc",  32'(lc(base + k)), 32'(s + k));
    end
    check("t5_busy", 32'(bus.busy), 32'd0);

    // rst during RELEASE with a second entry queued: nothing further.
    cpu_wr(1'b0, 16'hC0DE);
    cpu_wr(1'b1, 16'h8001);
    cpu_wr(1'b1, 16'h8001);
    tick(6);
    check("t6_in_release", 32'(bus.snd_wr_en), 32'd1);
    check("t6_rel_data",   32'(bus.snd_data),  32'hC000);
    pulse_rst();
    check_reset_outputs("t6_rst");
    base = log_cyc.size();
    tick(20);
    check("t6_no_writes", 32'(log_cyc.size() - base), 32'd0);

    // rst during SILENCE.
    pulse_stop();
    tick(1);
    check("t7_in_silence", 32'(bus.snd_data), 32'h4000);
    pulse_rst();
    check_reset_outputs("t7_rst");
    base = log_cyc.size();
    tick(10);
    check("t7_no_writes", 32'(log_cyc.size() - base), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
